// File: rtl/ripple_count_capture_pkg.sv
// Shared constants, filter-state encoding and helpers for ripple_count_capture.
package ripple_count_capture_pkg;

   localparam int unsigned DEF_WIDTH         = 4;
   localparam int unsigned DEF_STABLE_CYCLES = 2;
   localparam int unsigned DEF_WRAP_W        = 8;

   // Wide enough to hold STABLE_CYCLES-1 for the full legal range 1..15.
   localparam int unsigned STAB_W = 4;

   typedef enum logic {
      SETTLING = 1'b0,
      STABLE   = 1'b1
   } filt_state_e;

   // Largest value representable in 'width' bits (2^width - 1).
   function automatic logic [31:0] max_val(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/ripple_count_capture_sync_2ff.sv
// sync_2ff: per-bit two-flop synchronizer with async active-low reset.
// Ports: clk, rst_n, d (asynchronous input bus), q (synchronized bus).
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   // First stage may go metastable; second stage gives it a cycle to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings a free-running ripple counter into the clk
// domain, filters out ripple transients, and emits each settled new value on
// a valid/ready stream with wrap tracking and a sticky drop flag.
// Optional build macro RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN adds skip_err.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   count_in         raw ripple-counter value (asynchronous)
//   clr              sync clear of overrun / wrap_count (/ skip_err)
//   out_valid/ready  output handshake, out_data accepted value
//   wrap_pulse       one-cycle pulse on an accepted max->0 step
//   wrap_count       wrap tally modulo 2^WRAP_W
//   overrun          sticky: accepted value dropped under back-pressure
//   skip_err         (macro only) sticky: accepted value != last+1
module ripple_count_capture
   import ripple_count_capture_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned WRAP_W        = DEF_WRAP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
`ifdef RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN
   output logic              skip_err,
`endif
   output logic              overrun
);

   localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'(max_val(WIDTH));
   localparam logic [STAB_W-1:0] STAB_END = STAB_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]  s2;
   filt_state_e       state_q, state_d;
   logic [WIDTH-1:0]  cand_q, cand_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [WIDTH-1:0]  last_q;
   logic              accept_c;
   logic              drop_c;
   logic              wrap_c;

   sync_2ff #(.WIDTH(WIDTH)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (count_in),
      .q     (s2)
   );

   // Filter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE;
         cand_q  <= '0;
         stab_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         stab_q  <= stab_d;
      end
   end

   // Filter next-state: any change restarts the count; a candidate held for
   // STABLE_CYCLES samples is accepted once, then held until s2 moves again.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      stab_d   = stab_q;
      accept_c = 1'b0;
      case (state_q)
         SETTLING: begin
            if (s2 != cand_q) begin
               cand_d = s2;
               stab_d = '0;
            end else if (stab_q == STAB_END) begin
               state_d  = STABLE;
               accept_c = (cand_q != last_q);
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end
         STABLE: begin
            if (s2 != cand_q) begin
               cand_d  = s2;
               stab_d  = '0;
               state_d = SETTLING;
            end
         end
         default: state_d = STABLE;
      endcase
   end

   assign drop_c = accept_c && out_valid && !out_ready;
   assign wrap_c = accept_c && (cand_q == '0) && (last_q == MAX_V);

   // Output register, last accepted value and handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept_c) begin
            last_q <= cand_q;
            if (!out_valid || out_ready) begin
               out_data  <= cand_q;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Wrap tracking and sticky flags; a same-cycle event beats clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_pulse <= 1'b0;
         wrap_count <= '0;
         overrun    <= 1'b0;
      end else begin
         wrap_pulse <= wrap_c;
         if (clr) begin
            wrap_count <= wrap_c ? WRAP_W'(1) : '0;
         end else if (wrap_c) begin
            wrap_count <= wrap_count + WRAP_W'(1);
         end
         if (drop_c) begin
            overrun <= 1'b1;
         end else if (clr) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN
   logic skip_c;

   // Non-consecutive accepted value means counts were missed.
   assign skip_c = accept_c && (cand_q != last_q + WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_err <= 1'b0;
      end else if (skip_c) begin
         skip_err <= 1'b1;
      end else if (clr) begin
         skip_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed self-checking bench for ripple_count_capture with a scoreboard of
// expected emitted values, popped on each out_valid/out_ready handshake.
module tb_ripple_count_capture;

   logic       clk;
   logic       rst_n;
   logic [3:0] count_in;
   logic       clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       wrap_pulse;
   logic [7:0] wrap_count;
   logic       overrun;
`ifdef RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN
   logic       skip_err;
`endif

   int unsigned checks;
   int unsigned errors;
   int unsigned wrap_seen;
   logic [3:0]  exp_q[$];

   ripple_count_capture dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_in   (count_in),
      .clr        (clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
`ifdef RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN
      .skip_err   (skip_err),
`endif
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // One clock: check handshake/wrap at the negedge, return 1 time unit
   // after the following posedge so the caller can drive new inputs.
   task automatic tick();
      logic [3:0] want;
      @(negedge clk);
      if (wrap_pulse) begin
         wrap_seen++;
         chk("wrap_with_zero", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'd0});
      end
      if (out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_emit: observed %0h expected none", out_data);
         end
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("emit_data", 32'(out_data), 32'(want));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      wrap_seen = 0;
      rst_n     = 1'b0;
      count_in  = 4'd0;
      clr       = 1'b0;
      out_ready = 1'b1;
      #23;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_wrap_count", 32'(wrap_count), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ticks(4);
      chk("no_emit_initial_zero", 32'(out_valid), 32'd0);

      // First value: valid appears exactly at E4 and lasts one cycle.
      count_in = 4'd1;
      exp_q.push_back(4'd1);
      ticks(4);
      chk("lat_before_e4", 32'(out_valid), 32'd0);
      tick();
      chk("lat_at_e4_valid", 32'(out_valid), 32'd1);
      chk("lat_at_e4_data", 32'(out_data), 32'd1);
      tick();
      chk("one_cycle_valid", 32'(out_valid), 32'd0);
      ticks(4);

      // One-cycle glitch is filtered, then a held step is emitted once.
      count_in = 4'd3;
      tick();
      count_in = 4'd1;
      ticks(10);
      chk("glitch_no_valid", 32'(out_valid), 32'd0);
      count_in = 4'd2;
      exp_q.push_back(4'd2);
      ticks(8);

      // Wrap 14 -> 15 -> 0.
      count_in = 4'd14; exp_q.push_back(4'd14); ticks(8);
      count_in = 4'd15; exp_q.push_back(4'd15); ticks(8);
      count_in = 4'd0;  exp_q.push_back(4'd0);  ticks(8);
      chk("wrap_pulses", wrap_seen, 32'd1);
      chk("wrap_count", 32'(wrap_count), 32'd1);

      // Back-pressure: 5 is held, 6 is dropped.
      out_ready = 1'b0;
      count_in  = 4'd5; exp_q.push_back(4'd5); ticks(8);
      count_in  = 4'd6; ticks(8);
      chk("bp_data_held", 32'(out_data), 32'd5);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_overrun", 32'(overrun), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_overrun", 32'(overrun), 32'd0);
      chk("clr_wrap_count", 32'(wrap_count), 32'd0);

      // Drain of 3 coincides with acceptance of 7.
      out_ready = 1'b0;
      count_in  = 4'd3; exp_q.push_back(4'd3); ticks(8);
      count_in  = 4'd7; exp_q.push_back(4'd7); ticks(4);
      out_ready = 1'b1;
      tick();
      chk("sim_valid", 32'(out_valid), 32'd1);
      chk("sim_data", 32'(out_data), 32'd7);
      chk("sim_overrun", 32'(overrun), 32'd0);
      ticks(3);

`ifdef RIPPLE_COUNT_CAPTURE_SKIP_CHECK_EN
      count_in = 4'd2; exp_q.push_back(4'd2); ticks(8);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("skip_cleared", 32'(skip_err), 32'd0);
      count_in = 4'd4; exp_q.push_back(4'd4); ticks(8);
      chk("skip_set", 32'(skip_err), 32'd1);
`endif

      // Reset asserted while the filter is settling on a new value.
      out_ready = 1'b0;
      count_in  = 4'd9;  ticks(8);
      count_in  = 4'd10; ticks(8);
      chk("pre_rst_data", 32'(out_data), 32'd9);
      chk("pre_rst_overrun", 32'(overrun), 32'd1);
      count_in = 4'd11;
      ticks(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      chk("mid_rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
      chk("mid_rst_wrap_count", 32'(wrap_count), 32'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(4'd11);
      ticks(10);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
